// File: rtl/sram_stream_fifo_ctrl_if.sv
// Bundle of the pixel-stream handshakes and the SRAM command bus for sram_stream_fifo_ctrl.
// Optional fill-level signals exist only when SRAM_FIFO_LEVEL_EN is defined.
interface sram_stream_fifo_ctrl_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              cs_n;
  logic              wr_n;
  logic [ADDR_W-1:0] wraddr;
  logic [ADDR_W-1:0] rdaddr;
  logic [DATA_W-1:0] wrdata;
  logic [DATA_W-1:0] rddata;
`ifdef SRAM_FIFO_LEVEL_EN
  logic [ADDR_W+1:0] level;
  logic              hwm_hit;
`endif

  modport master (
    input  in_valid, in_data, out_ready, rddata,
    output in_ready, out_valid, out_data, cs_n, wr_n, wraddr, rdaddr, wrdata
`ifdef SRAM_FIFO_LEVEL_EN
    , output level, hwm_hit
`endif
  );

  modport slave (
    output in_valid, in_data, out_ready, rddata,
    input  in_ready, out_valid, out_data, cs_n, wr_n, wraddr, rdaddr, wrdata
`ifdef SRAM_FIFO_LEVEL_EN
    , input level, hwm_hit
`endif
  );
endinterface

// File: rtl/sram_stream_fifo_ctrl.sv
// Ring-buffer FIFO in a single-command SRAM with a 2-entry output buffer.
// Optional macro SRAM_FIFO_LEVEL_EN adds the registered LEVEL and sticky HWM_HIT outputs.
module sram_stream_fifo_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  sram_stream_fifo_ctrl_if.master bus
);
  localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] PTR_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  logic [ADDR_W:0]   wr_ptr;
  logic [ADDR_W:0]   rd_ptr;
  logic [ADDR_W:0]   cnt;
  logic [1:0]        occ;
  logic              infl;
  logic              prio_wr;
  logic [DATA_W-1:0] head;
  logic [DATA_W-1:0] spare;
  logic [ADDR_W-1:0] wraddr_q;
  logic [ADDR_W-1:0] rdaddr_q;
  logic [DATA_W-1:0] wrdata_q;
  logic              full;
  logic              pop;
  logic [2:0]        pending;
  logic              rd_want;
  logic              rd_go;
  logic              in_ready;
  logic              wr_go;

  // A read is only worth issuing if its result will still fit in the buffer when it lands.
  always_comb begin
    cnt      = wr_ptr - rd_ptr;
    full     = (cnt == FULL_CNT);
    pop      = (occ != 2'd0) && bus.out_ready;
    pending  = {1'b0, occ} + {2'b00, infl} - {2'b00, pop};
    rd_want  = (cnt != '0) && (pending < 3'd2);
    rd_go    = rd_want && !(prio_wr && bus.in_valid && !full);
    in_ready = !rst && !full && !rd_go;
    wr_go    = bus.in_valid && in_ready;
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (occ != 2'd0);
  assign bus.out_data  = head;
  assign bus.cs_n      = !(wr_go || rd_go);
  assign bus.wr_n      = !wr_go;
  assign bus.wraddr    = wr_go ? wr_ptr[ADDR_W-1:0] : wraddr_q;
  assign bus.rdaddr    = rd_go ? rd_ptr[ADDR_W-1:0] : rdaddr_q;
  assign bus.wrdata    = wr_go ? bus.in_data : wrdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      infl     <= 1'b0;
      prio_wr  <= 1'b0;
      wraddr_q <= '0;
      rdaddr_q <= '0;
      wrdata_q <= '0;
    end else begin
      infl <= rd_go;
      if (wr_go) begin
        wr_ptr   <= wr_ptr + PTR_ONE;
        wraddr_q <= wr_ptr[ADDR_W-1:0];
        wrdata_q <= bus.in_data;
        prio_wr  <= 1'b0;
      end
      if (rd_go) begin
        rd_ptr   <= rd_ptr + PTR_ONE;
        rdaddr_q <= rd_ptr[ADDR_W-1:0];
        prio_wr  <= 1'b1;
      end
    end
  end

  // head is the visible word; spare only fills when head is occupied and not leaving.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ   <= 2'd0;
      head  <= '0;
      spare <= '0;
    end else begin
      occ <= occ + {1'b0, infl} - {1'b0, pop};
      if (pop && (occ == 2'd2)) begin
        head <= spare;
        if (infl) spare <= bus.rddata;
      end else if (infl && ((occ == 2'd0) || ((occ == 2'd1) && pop))) begin
        head <= bus.rddata;
      end else if (infl && (occ == 2'd1)) begin
        spare <= bus.rddata;
      end
    end
  end

`ifdef SRAM_FIFO_LEVEL_EN
  localparam logic [ADDR_W:0] HWM_CNT = FULL_CNT - PTR_ONE;

  logic [ADDR_W+1:0] level;
  logic              hwm_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level   <= '0;
      hwm_hit <= 1'b0;
    end else begin
      level <= {1'b0, cnt} + {{(ADDR_W+1){1'b0}}, infl} + {{ADDR_W{1'b0}}, occ};
      if (cnt == HWM_CNT) hwm_hit <= 1'b1;
    end
  end

  assign bus.level   = level;
  assign bus.hwm_hit = hwm_hit;
`endif
endmodule

// File: tb/tb_sram_stream_fifo_ctrl.sv
// Self-checking bench for sram_stream_fifo_ctrl: SRAM model plus a queue scoreboard.
// Define SRAM_FIFO_LEVEL_EN to also exercise the LEVEL/HWM_HIT outputs.
module tb_sram_stream_fifo_ctrl;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int CAP    = DEPTH + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_stream_fifo_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sram_stream_fifo_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // SRAM behaviour: writes land at the edge, reads return one cycle later, 0 otherwise.
  logic [DATA_W-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (!bus.cs_n && !bus.wr_n) mem[bus.wraddr] <= bus.wrdata;
    if (!bus.cs_n && bus.wr_n) bus.rddata <= mem[bus.rdaddr];
    else bus.rddata <= '0;
  end

  // Scoreboard: words accepted but not yet delivered, plus SRAM command counters.
  logic [DATA_W-1:0] model_q [$];
  int wr_model  = 0;
  int rd_model  = 0;
  int pop_count = 0;

  always @(negedge clk) begin
    if (rst) begin
      model_q.delete();
      wr_model = 0;
      rd_model = 0;
    end else begin
      if (model_q.size() == 0) check_output("valid_when_empty", 32'(bus.out_valid), 32'd0);
      else if (bus.out_valid) check_output("out_data_order", 32'(bus.out_data), 32'(model_q[0]));
      if (model_q.size() >= CAP) check_output("in_ready_when_full", 32'(bus.in_ready), 32'd0);
      if (!bus.cs_n && bus.wr_n) begin
        check_output("rdaddr", 32'(bus.rdaddr), 32'(rd_model % DEPTH));
        check_output("read_needs_data", 32'(rd_model < wr_model), 32'd1);
      end
      if (bus.in_valid && bus.in_ready) begin
        check_output("accept_is_write", {30'd0, bus.cs_n, bus.wr_n}, 32'd0);
        check_output("wraddr", 32'(bus.wraddr), 32'(wr_model % DEPTH));
        check_output("wrdata", 32'(bus.wrdata), 32'(bus.in_data));
      end else begin
        check_output("write_without_accept", 32'(!bus.cs_n && !bus.wr_n), 32'd0);
      end
      if (bus.out_valid && bus.out_ready && model_q.size() > 0) begin
        void'(model_q.pop_front());
        pop_count++;
      end
      if (!bus.cs_n && bus.wr_n) rd_model++;
      if (bus.in_valid && bus.in_ready) begin
        model_q.push_back(bus.in_data);
        wr_model++;
      end
    end
  end

  initial begin
    int n;
    int p0;
    int gaps;
    int repeats;
    int acc;
    int vis;
    logic prev_wr_n;
    logic seen;

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (2) tick();
    $display("[TB] reset state");
    check_output("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check_output("rst_cs_n", 32'(bus.cs_n), 32'd1);
    check_output("rst_wr_n", 32'(bus.wr_n), 32'd1);
    check_output("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_output("rst_out_data", 32'(bus.out_data), 32'd0);
    check_output("rst_wraddr", 32'(bus.wraddr), 32'd0);
    check_output("rst_rdaddr", 32'(bus.rdaddr), 32'd0);
    check_output("rst_wrdata", 32'(bus.wrdata), 32'd0);
    rst = 1'b0;
    tick();

    $display("[TB] single word latency");
    bus.in_valid  = 1'b1;
    bus.in_data   = 16'h1234;
    bus.out_ready = 1'b1;
    #1;
    check_output("t1_in_ready", 32'(bus.in_ready), 32'd1);
    check_output("t1_write_cmd", {30'd0, bus.cs_n, bus.wr_n}, 32'd0);
    check_output("t1_wraddr", 32'(bus.wraddr), 32'd0);
    check_output("t1_wrdata", 32'(bus.wrdata), 32'h1234);
    tick();
    bus.in_valid = 1'b0;
    #1;
    check_output("t1_read_cmd", {30'd0, bus.cs_n, bus.wr_n}, 32'd1);
    check_output("t1_rdaddr", 32'(bus.rdaddr), 32'd0);
    tick();
    check_output("t1_not_yet_valid", 32'(bus.out_valid), 32'd0);
    tick();
    check_output("t1_out_valid", 32'(bus.out_valid), 32'd1);
    check_output("t1_out_data", 32'(bus.out_data), 32'h1234);
    repeat (3) tick();

    $display("[TB] fill to capacity then drain");
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    n = 0;
    for (int c = 0; c < 2500; c++) begin
      bus.in_data = DATA_W'(n);
      #2;
      if (bus.in_ready) n++;
      tick();
    end
    bus.in_valid = 1'b0;
    check_output("fill_count", 32'(n), 32'(CAP));
    check_output("full_in_ready", 32'(bus.in_ready), 32'd0);
    p0 = pop_count;
    bus.out_ready = 1'b1;
    repeat (1100) tick();
    check_output("drain_count", 32'(pop_count - p0), 32'(CAP));

    $display("[TB] contention at half full");
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    n = 0;
    for (int c = 0; c < 2000 && n < DEPTH / 2; c++) begin
      bus.in_data = DATA_W'($urandom);
      #2;
      if (bus.in_ready) n++;
      tick();
    end
    bus.out_ready = 1'b1;
    repeat (4) tick();
    gaps = 0; repeats = 0; acc = 0; vis = 0; seen = 1'b0; prev_wr_n = 1'b0;
    for (int c = 0; c < 200; c++) begin
      bus.in_data = DATA_W'($urandom);
      #2;
      if (bus.cs_n) gaps++;
      else begin
        if (seen && (bus.wr_n == prev_wr_n)) repeats++;
        prev_wr_n = bus.wr_n;
        seen = 1'b1;
      end
      if (bus.in_ready) acc++;
      if (bus.out_valid) vis++;
      tick();
    end
    check_output("contend_idle_cycles", 32'(gaps), 32'd0);
    check_output("contend_repeats", 32'(repeats), 32'd0);
    check_output("contend_writes", 32'(acc), 32'd100);
    check_output("contend_outputs", 32'(vis), 32'd100);
    bus.in_valid = 1'b0;
    repeat (1100) tick();
    check_output("contend_drained", 32'(model_q.size()), 32'd0);

    $display("[TB] random traffic, 3000 words");
    p0 = pop_count;
    n = 0;
    for (int c = 0; c < 20000 && (pop_count - p0) < 3000; c++) begin
      bus.in_valid  = (n < 3000) && ($urandom_range(0, 9) < 7);
      bus.in_data   = DATA_W'($urandom);
      bus.out_ready = ($urandom_range(0, 9) < 6);
      #2;
      if (bus.in_valid && bus.in_ready) n++;
      tick();
    end
    bus.in_valid = 1'b0;
    check_output("random_pushed", 32'(n), 32'd3000);
    check_output("random_popped", 32'(pop_count - p0), 32'd3000);

    $display("[TB] reset mid-burst");
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    n = 0;
    for (int c = 0; c < 50 && n < 5; c++) begin
      bus.in_data = DATA_W'(16'h0100 + n);
      #2;
      if (bus.in_ready) n++;
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    rst = 1'b1;
    #1;
    check_output("rstmid_out_valid", 32'(bus.out_valid), 32'd0);
    check_output("rstmid_cs_n", 32'(bus.cs_n), 32'd1);
    check_output("rstmid_in_ready", 32'(bus.in_ready), 32'd0);
    check_output("rstmid_out_data", 32'(bus.out_data), 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check_output("rstmid_dropped_read", 32'(bus.out_valid), 32'd0);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'hBEEF;
    #1;
    check_output("rstmid_accept", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      #1;
      if (bus.out_valid) seen = 1'b1;
      else tick();
    end
    check_output("rstmid_valid_seen", 32'(seen), 32'd1);
    check_output("rstmid_first_word", 32'(bus.out_data), 32'hBEEF);
    repeat (3) tick();

`ifdef SRAM_FIFO_LEVEL_EN
    $display("[TB] level and high-water mark");
    check_output("hwm_after_reset", 32'(bus.hwm_hit), 32'd0);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    for (int c = 0; c < 1200; c++) begin
      bus.in_data = DATA_W'($urandom);
      tick();
    end
    bus.in_valid = 1'b0;
    repeat (3) tick();
    check_output("level_full", 32'(bus.level), 32'(model_q.size()));
    check_output("level_full_value", 32'(bus.level), 32'(CAP));
    check_output("hwm_set", 32'(bus.hwm_hit), 32'd1);
    bus.out_ready = 1'b1;
    repeat (1100) tick();
    check_output("level_empty", 32'(bus.level), 32'(model_q.size()));
    check_output("hwm_sticky", 32'(bus.hwm_hit), 32'd1);
    rst = 1'b1;
    #1;
    check_output("hwm_cleared", 32'(bus.hwm_hit), 32'd0);
    check_output("level_cleared", 32'(bus.level), 32'd0);
    tick();
    rst = 1'b0;
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
